// File: rtl/pkt_tx_sched.sv
// Round-robin transmit scheduler: picks one requester, loads the packet register, then shifts it out.
// Optional even-parity cycle after the shift, enabled by defining PKT_SCHED_PARITY_EN.
module pkt_tx_sched #(
    parameter int NREQ  = 2,
    parameter int PKT_W = 64,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*PKT_W-1:0] pkt_in,
    output logic [NREQ-1:0]       gnt,
    output logic [PKT_W-1:0]      pkt_din,
    output logic                  pkt_rec,
    output logic                  pkt_flg,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  par_out,
    output logic                  par_vld
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef PKT_SCHED_PARITY_EN
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_idx;
    logic             win_vld;
    logic             done_d;
    logic             last_bit;
    int               arb_i;

    assign last_bit = (bit_cnt == CNT_W'(PKT_W - 1));

    // First asserted request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        arb_i   = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_i = (int'(rr_ptr) + k) % NREQ;
            if (!win_vld && req[arb_i]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(arb_i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (win_vld) state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: if (last_bit) begin
`ifdef PKT_SCHED_PARITY_EN
                state_d = PARITY;
`else
                state_d = IDLE;
                done_d  = 1'b1;
`endif
            end
`ifdef PKT_SCHED_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            gnt     <= '0;
            pkt_din <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            gnt     <= '0;
            if (state_q == IDLE && win_vld) begin
                gnt     <= NREQ'(1) << win_idx;
                pkt_din <= pkt_in[int'(win_idx)*PKT_W +: PKT_W];
                rr_ptr  <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
            end
            // bit_cnt follows the shift position and parks at 0 elsewhere
            if (state_q == SHIFT && !last_bit) bit_cnt <= bit_cnt + CNT_W'(1);
            else                               bit_cnt <= '0;
        end
    end

    assign pkt_rec = (state_q == LOAD);
    assign pkt_flg = (state_q == SHIFT);
    assign busy    = (state_q != IDLE);

`ifdef PKT_SCHED_PARITY_EN
    assign par_vld = (state_q == PARITY);
    assign par_out = (state_q == PARITY) ? ^pkt_din : 1'b0;
`else
    assign par_vld = 1'b0;
    assign par_out = 1'b0;
`endif
endmodule

// File: doc/pkt_tx_sched.md
# pkt_tx_sched

Transmit scheduler for the 64-bit packet shift register. Up to four requesters each present a parallel packet. The block grants one requester at a time in round-robin order, loads the packet register with a one-cycle `pkt_rec` pulse, then holds `pkt_flg` for exactly PKT_W cycles so the packet shifts out serially. It sits between the packet sources and the packet register and owns every control input of that register.

## Interface
- `NREQ`, default 2: number of requesters, legal range 1..4.
- `PKT_W`, default 64: packet width, which is also the shift length.
- `CNT_W`, default 6: bit-counter width, equal to clog2(PKT_W).

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: request per requester; level-sensitive.
- `pkt_in`  in  NREQ*PKT_W: requester i's packet sits at `[i*PKT_W +: PKT_W]`.
- `gnt`  out  NREQ: one-hot, one-cycle pulse meaning "packet captured".
- `pkt_din`  out  PKT_W: registered copy of the granted packet; drives the register's `din`.
- `pkt_rec`  out  1: load strobe to the packet register.
- `pkt_flg`  out  1: shift enable to the packet register.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse after a packet (and its parity bit, if enabled) completes.
- `bit_cnt`  out  CNT_W: index of the bit currently shifting; 0 outside SHIFT.
- `par_out`  out  1: even-parity bit of `pkt_din`.
- `par_vld`  out  1: qualifies `par_out`.

## Operation
States are IDLE, LOAD, SHIFT and PARITY. PARITY exists only when the macro below is defined.

- **IDLE:** `req` is sampled only in this state. Nothing happens if `req == 0`.
- **Arbitration:** the search starts at pointer `rr_ptr` and wraps modulo NREQ; the first asserted `req` wins.
- **On a win at edge:**
  - `gnt[w] <= 1`
  - `pkt_din <= pkt_in[w]`
  - `pkt_rec <= 1`
  - `rr_ptr <= (w+1) mod NREQ`
  - state goes to LOAD.
- **LOAD:** lasts exactly one cycle, with `gnt` and `pkt_rec` high. Next state is SHIFT; `gnt` and `pkt_rec` return to 0.
- **SHIFT:**
  - `pkt_flg = 1`.
  - `bit_cnt` increments from 0 to PKT_W-1.
  - At `bit_cnt == PKT_W-1` the next state is PARITY if the macro is defined, otherwise IDLE with `done` set.
- **PARITY:** lasts one cycle.
  - `pkt_flg = 0`, `par_vld = 1`, `par_out = ^pkt_din`.
  - Next state is IDLE with `done` set.
- **Requester contract:**
  - Hold `req` and `pkt_in` stable until `gnt`.
  - Deassert `req` within PKT_W cycles after `gnt`; a `req` still high back in IDLE counts as a new request.
- **Data stability:** `pkt_din` holds its value until the next grant. It is never cleared between packets.
- **Pointer behaviour:** `rr_ptr` is 0 after reset. With NREQ = 1 it stays at 0.

## Timing
- **Reset:** assertion is seen at the next edge. Every output becomes 0 (including `pkt_din` and `bit_cnt`), state goes to IDLE and `rr_ptr` to 0.
- **Reset mid-packet:** shifting aborts and no `done` is produced.
- **Packet timeline:** with a grant decided in IDLE at cycle t:
  - t+1: `pkt_rec`/`gnt` high.
  - t+2 .. t+PKT_W+1: `pkt_flg` high.
  - With parity: `par_vld` at t+PKT_W+2, then `done` at t+PKT_W+3.
  - Without parity: `done` at t+PKT_W+2.
- **Back-to-back packets:** the `done` cycle is an IDLE cycle, so arbitration happens in that same cycle. A pending request sees `pkt_rec` in the cycle right after `done`. Throughput is one packet per PKT_W+2 cycles (PKT_W+3 with parity).
- **Simultaneous requests:** exactly one grant per IDLE cycle. Losers keep waiting and are served in round-robin order, so there is no starvation.
- **Signal relationships:**
  - `pkt_rec` and `pkt_flg` are never high in the same cycle.
  - `gnt` is always a single bit or zero.
  - `busy` is high from the LOAD cycle through the final SHIFT/PARITY cycle and low in the `done` cycle.

## Configuration
- `PKT_SCHED_PARITY_EN`:
  - **Defined:** the PARITY state is compiled in, adding one cycle per packet that presents the even-parity bit on `par_out` with `par_vld`.
  - **Undefined:** there is no PARITY state, `par_out` and `par_vld` are tied to 0, and `done` follows the last SHIFT cycle directly.

## Test plan
- **Reset values:** NREQ=2, assert `rst` for 2 cycles, then release -> all outputs are 0 and `busy` = 0.
- **Single packet:** `req[0]=1`, `pkt_in[0]=64'hAAAAAAAAAAAAAAAA` -> `gnt=2'b01` and `pkt_rec` for 1 cycle, `pkt_din` = AAAA…, `pkt_flg` high for exactly 64 cycles with `bit_cnt` 0..63, then one `done`.
- **Contention and fairness:** hold `req=2'b11` continuously -> grants alternate 01, 10, 01. Each `pkt_rec` comes one cycle after the previous `done` (66-cycle period without parity).
- **Parity (macro defined):** `pkt_in[1]=64'h1` -> after 64 shift cycles, `par_vld=1` and `par_out=1`, then `done`. For `64'h3` -> `par_out=0`.
- **Reset mid-shift:** assert `rst` at `bit_cnt=20` -> next cycle `pkt_flg=0`, `bit_cnt=0`, no `done`; the following grant goes to requester 0.
- **Four requesters:** NREQ=4, `req=4'b1010` while `rr_ptr=2` -> `gnt=4'b1000`, then `gnt=4'b0010`.
